// File: rtl/iiitb_rtc_disp.sv
// Six-digit multiplexed seven-segment scanner for the RTC hh:mm:ss digits.
// Optional leading-zero blanking of the tens-of-hours digit via `IIITB_RTC_DISP_LZB_EN.
module iiitb_rtc_disp #(
  parameter int REFRESH_DIV    = 1000,
  parameter int GUARD          = 4,
  parameter bit SEG_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] hrm,
  input  logic [3:0] hrl,
  input  logic [3:0] minm,
  input  logic [3:0] minl,
  input  logic [3:0] secm,
  input  logic [3:0] secl,
  input  logic       blank,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an,
  output logic       frame_done
);

  localparam int            PW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PC_MAX   = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] PC_GUARD = PW'(GUARD);
  localparam logic [6:0]    SEG_POL  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [5:0]    AN_POL   = SEG_ACTIVE_LOW ? 6'h3F : 6'h00;
  localparam logic          DP_POL   = SEG_ACTIVE_LOW;

  typedef enum logic {
    GUARD_S,
    DRIVE_S
  } state_t;

  localparam state_t SLOT_START_S = (GUARD > 0) ? GUARD_S : DRIVE_S;

  logic [PW-1:0] r_pc;
  logic [2:0]    r_slot;
  logic [23:0]   r_snap;
  state_t        r_state;
  state_t        w_stateNext;
  logic          w_tick;
  logic          w_frameEnd;
  logic [PW-1:0] w_pcNext;
  logic [2:0]    w_slotNext;
  logic [3:0]    w_digit;
  logic [6:0]    w_segHi;
  logic [5:0]    w_anHi;
  logic          w_dpHi;

  function automatic logic [6:0] decodeDigit(input logic [3:0] d);
    case (d)
      4'd0:    decodeDigit = 7'h3F;
      4'd1:    decodeDigit = 7'h06;
      4'd2:    decodeDigit = 7'h5B;
      4'd3:    decodeDigit = 7'h4F;
      4'd4:    decodeDigit = 7'h66;
      4'd5:    decodeDigit = 7'h6D;
      4'd6:    decodeDigit = 7'h7D;
      4'd7:    decodeDigit = 7'h07;
      4'd8:    decodeDigit = 7'h7F;
      4'd9:    decodeDigit = 7'h6F;
      default: decodeDigit = 7'h40;
    endcase
  endfunction

  assign w_tick     = (r_pc == PC_MAX);
  assign w_frameEnd = w_tick && (r_slot == 3'd5);
  assign w_pcNext   = w_tick ? '0 : r_pc + 1'b1;
  assign w_slotNext = !w_tick ? r_slot : ((r_slot == 3'd5) ? 3'd0 : r_slot + 3'd1);

  // Snapshot is {hrm,hrl,minm,minl,secm,secl}; it is the only source for display.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= '0;
      r_slot  <= 3'd0;
      r_snap  <= 24'd0;
      r_state <= SLOT_START_S;
    end else begin
      r_pc    <= w_pcNext;
      r_slot  <= w_slotNext;
      r_state <= w_stateNext;
      if (w_frameEnd) begin
        r_snap <= {hrm, hrl, minm, minl, secm, secl};
      end
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_anHi      = 6'd0;
    w_segHi     = 7'd0;
    w_dpHi      = 1'b0;
    w_digit     = 4'd0;

    case (r_state)
      GUARD_S: w_stateNext = (w_pcNext >= PC_GUARD) ? DRIVE_S : GUARD_S;
      DRIVE_S: w_stateNext = w_tick ? SLOT_START_S : DRIVE_S;
      default: w_stateNext = SLOT_START_S;
    endcase

    case (r_slot)
      3'd0:    w_digit = r_snap[3:0];
      3'd1:    w_digit = r_snap[7:4];
      3'd2:    w_digit = r_snap[11:8];
      3'd3:    w_digit = r_snap[15:12];
      3'd4:    w_digit = r_snap[19:16];
      default: w_digit = r_snap[23:20];
    endcase

    if (r_state == DRIVE_S && !blank) begin
      w_anHi  = 6'b000001 << r_slot;
      w_segHi = decodeDigit(w_digit);
      w_dpHi  = (r_slot == 3'd2) || (r_slot == 3'd4);
`ifdef IIITB_RTC_DISP_LZB_EN
      if (r_slot == 3'd5 && r_snap[23:20] == 4'd0) begin
        w_anHi  = 6'd0;
        w_segHi = 7'd0;
      end
`endif
    end
  end

  // Output stage: one cycle behind the scan state, polarity applied here.
  always_ff @(posedge clk) begin
    if (rst) begin
      an         <= AN_POL;
      seg        <= SEG_POL;
      dp         <= DP_POL;
      frame_done <= 1'b0;
    end else begin
      an         <= w_anHi ^ AN_POL;
      seg        <= w_segHi ^ SEG_POL;
      dp         <= w_dpHi ^ DP_POL;
      frame_done <= w_frameEnd;
    end
  end

endmodule

// File: tb/tb_iiitb_rtc_disp.sv
// Directed bench for iiitb_rtc_disp: REFRESH_DIV=8, GUARD=2, active-low outputs.
// Honours `IIITB_RTC_DISP_LZB_EN when it is defined for the build.
module tb_iiitb_rtc_disp;

  logic       clk;
  logic       rst;
  logic [3:0] hrm, hrl, minm, minl, secm, secl;
  logic       blank;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;
  logic       frame_done;

`ifdef IIITB_RTC_DISP_LZB_EN
  localparam bit LZB_EN = 1'b1;
`else
  localparam bit LZB_EN = 1'b0;
`endif

  int         total = 0;
  int         bad   = 0;
  int         gIdx  = 0;
  int         changeAt   = -1;
  logic [23:0] changeVal = 24'h0;
  int         blankStart = -1;
  int         blankEnd   = -1;
  logic [6:0] expSegTab [0:5];
  bit         hrmZero;

  iiitb_rtc_disp #(
    .REFRESH_DIV(8),
    .GUARD(2),
    .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hrm(hrm),
    .hrl(hrl),
    .minm(minm),
    .minl(minl),
    .secm(secm),
    .secl(secl),
    .blank(blank),
    .seg(seg),
    .dp(dp),
    .an(an),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("[TB] FAIL %s idx=%0d: got %0h expected %0h", tag, gIdx, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic [23:0] t);
    {hrm, hrl, minm, minl, secm, secl} = t;
  endtask

  // Segment values per slot, packed {slot5,...,slot0}.
  task automatic setTab(input logic [41:0] v, input bit zeroHrm);
    for (int s = 0; s < 6; s++) expSegTab[s] = v[s*7 +: 7];
    hrmZero = zeroHrm;
  endtask

  // Walks one full frame (48 cycles); the last cycle carries the next frame_done.
  task automatic checkFrame();
    int         s;
    int         c;
    bit         dark;
    logic [5:0] onehot;
    logic [5:0] expAn;
    logic [6:0] expSeg;
    logic       expDp;
    for (int i = 0; i < 48; i++) begin
      s = i / 8;
      c = i % 8;
      @(negedge clk);
      dark = (c < 2) || (gIdx > blankStart && gIdx <= blankEnd) ||
             (s == 5 && LZB_EN && hrmZero);
      onehot = 6'b000001 << s;
      expAn  = dark ? 6'h3F : ~onehot;
      expSeg = dark ? 7'h7F : expSegTab[s];
      expDp  = (!dark && (s == 2 || s == 4)) ? 1'b0 : 1'b1;
      checkOutput("an", 32'(an), 32'(expAn));
      checkOutput("seg", 32'(seg), 32'(expSeg));
      checkOutput("dp", 32'(dp), 32'(expDp));
      checkOutput("frame_done", 32'(frame_done), (i == 47) ? 32'd1 : 32'd0);
      if (gIdx == changeAt) applyStimulus(changeVal);
      if (gIdx == blankStart) blank = 1'b1;
      if (gIdx == blankEnd) blank = 1'b0;
      gIdx++;
    end
  endtask

  task automatic checkReset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_an", 32'(an), 32'h3F);
    checkOutput("rst_seg", 32'(seg), 32'h7F);
    checkOutput("rst_dp", 32'(dp), 32'h1);
    checkOutput("rst_fd", 32'(frame_done), 32'h0);
    rst = 1'b0;
  endtask

  initial begin
    blank = 1'b0;
    applyStimulus(24'h987654);
    checkReset();
    applyStimulus(24'h123456);

    setTab({7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}, 1'b1);
    checkFrame();

    setTab({7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}, 1'b0);
    checkFrame();

    changeAt  = 122;
    changeVal = 24'h235959;
    checkFrame();

    setTab({7'h24, 7'h30, 7'h12, 7'h10, 7'h12, 7'h10}, 1'b0);
    changeAt  = 154;
    changeVal = 24'h235B59;
    checkFrame();

    setTab({7'h24, 7'h30, 7'h12, 7'h3F, 7'h12, 7'h10}, 1'b0);
    blankStart = 245;
    blankEnd   = 345;
    repeat (3) checkFrame();

    changeAt  = 356;
    changeVal = 24'h075B59;
    checkFrame();

    setTab({7'h40, 7'h78, 7'h12, 7'h3F, 7'h12, 7'h10}, 1'b1);
    checkFrame();

    repeat (13) @(negedge clk);
    checkReset();
    gIdx       = 0;
    changeAt   = -1;
    blankStart = -1;
    blankEnd   = -1;
    setTab({7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}, 1'b1);
    checkFrame();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
